// File: rtl/rs232_tx_arb_pkg.sv
// Shared types and helpers for the RS-232 transmit arbiter.
// Holds the FSM state encoding and the clogb2 width helper.
package rs232_tx_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  // Number of bits needed to index 'value' items (ceil(log2(value))).
  function automatic int clogb2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

endpackage

// File: rtl/rs232_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
// The request vector is doubled so the wrap becomes a plain upward search.
module rs232_tx_arb_rr_pick
  import rs232_tx_arb_pkg::*;
#(
  parameter int P_NCLIENTS = 4,
  localparam int W = clogb2(P_NCLIENTS)
) (
  input  logic [P_NCLIENTS-1:0] req,
  input  logic [W-1:0]          ptr,
  output logic [W-1:0]          winner,
  output logic                  valid
);

  logic [2*P_NCLIENTS-1:0] dbl;

  assign dbl = {req, req};

  // NOTE: every output gets a default before the search so no latch is inferred.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    // Descending scan: the lowest qualifying index is written last and wins.
    for (int i = 2 * P_NCLIENTS - 1; i >= 0; i--) begin
      if (dbl[i] && (i >= int'(ptr))) begin
        valid  = 1'b1;
        winner = W'(i % P_NCLIENTS);
      end
    end
  end

endmodule

// File: rtl/rs232_tx_arb.sv
// Round-robin arbiter sharing one RS-232 serializer among several byte sources.
// A client holding cl_last low keeps the serializer until its message ends or stalls.
module rs232_tx_arb
  import rs232_tx_arb_pkg::*;
#(
  parameter int P_NCLIENTS     = 4,
  parameter int P_LOCK_TIMEOUT = 65535
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [P_NCLIENTS-1:0]           cl_req,
  input  logic [8*P_NCLIENTS-1:0]         cl_data,
  input  logic [P_NCLIENTS-1:0]           cl_last,
  output logic [P_NCLIENTS-1:0]           cl_ack,
  output logic                            ser_req,
  output logic [7:0]                      ser_data,
  input  logic                            ser_ack,
  output logic [clogb2(P_NCLIENTS)-1:0]   grant_id,
  output logic                            busy
);

  localparam int W  = clogb2(P_NCLIENTS);
  localparam int CW = clogb2(P_LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(P_LOCK_TIMEOUT - 1);
  localparam logic [W-1:0]  LAST_ID   = W'(P_NCLIENTS - 1);
  localparam logic [P_NCLIENTS-1:0] ONE = P_NCLIENTS'(1);

  state_t         state;
  logic [W-1:0]   rr_ptr;
  logic           lock_r;
  logic [CW-1:0]  lock_cnt;

  logic [W-1:0]   pick_id;
  logic           pick_valid;
  logic           take;
  logic [W-1:0]   take_id;
  logic [W-1:0]   next_ptr;

  rs232_tx_arb_rr_pick #(.P_NCLIENTS(P_NCLIENTS)) u_pick (
    .req    (cl_req),
    .ptr    (rr_ptr),
    .winner (pick_id),
    .valid  (pick_valid)
  );

  assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
  assign busy     = (state != S_IDLE);

  // While locked only the owner may be served; otherwise the picker decides.
  always_comb begin
    take    = 1'b0;
    take_id = pick_id;
    case (state)
      S_IDLE: take = pick_valid;
      S_LOCK: begin
        take    = cl_req[grant_id];
        take_id = grant_id;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      lock_r   <= 1'b0;
      lock_cnt <= '0;
      grant_id <= '0;
      ser_data <= '0;
      ser_req  <= 1'b0;
      cl_ack   <= '0;
    end else begin
      cl_ack <= '0;
      case (state)
        S_IDLE, S_LOCK: begin
          if (take) begin
            grant_id <= take_id;
            ser_data <= cl_data[8*take_id +: 8];
            lock_r   <= ~cl_last[take_id];
            cl_ack   <= ONE << take_id;
            ser_req  <= 1'b1;
            state    <= S_ISSUE;
          end else if (state == S_LOCK) begin
            lock_cnt <= lock_cnt + 1'b1;
            if (lock_cnt == LOCK_LAST) begin
              rr_ptr <= next_ptr;
              state  <= S_IDLE;
            end
          end
        end
        S_ISSUE: begin
          if (ser_ack) begin
            ser_req <= 1'b0;
            if (lock_r) begin
              lock_cnt <= '0;
              state    <= S_LOCK;
            end else begin
              rr_ptr <= next_ptr;
              state  <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_tx_arb.sv
// Bench for rs232_tx_arb: directed scenarios followed by randomized traffic,
// all compared cycle by cycle against a message-level model of the arbiter.
module tb_rs232_tx_arb;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int W  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     cl_req, cl_last, cl_ack;
  logic [8*N-1:0]   cl_data;
  logic             ser_req, ser_ack, busy;
  logic [7:0]       ser_data;
  logic [W-1:0]     grant_id;

  always #5 clk = ~clk;

  rs232_tx_arb #(.P_NCLIENTS(N), .P_LOCK_TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cl_req   (cl_req),
    .cl_data  (cl_data),
    .cl_last  (cl_last),
    .cl_ack   (cl_ack),
    .ser_req  (ser_req),
    .ser_data (ser_data),
    .ser_ack  (ser_ack),
    .grant_id (grant_id),
    .busy     (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Client byte streams: {last, byte} per entry.
  logic [8:0] cq [N][128];
  int head [N];
  int tail [N];
  bit present [N];
  int rate [N];
  int ack_step [N];

  // Model: owner/lock view of the arbiter plus the serializer's view.
  bit         m_inflight, m_lock;
  int         m_idle, m_rr;
  logic [N-1:0] e_ack;
  logic       e_req;
  logic [7:0] e_data;
  int         e_gid;
  logic [7:0] sent [$];
  int         wait_cnt, stepn;
  bit         rnd_mode, spur_en, force_sack;

  task automatic push(input int c, input bit last, input logic [7:0] b);
    cq[c][tail[c]] = {last, b};
    tail[c]++;
  endtask

  function automatic logic [15:0] sent_at(input int i);
    return (sent.size() > i) ? {8'h00, sent[i]} : 16'hFFFF;
  endfunction

  task automatic model_reset();
    m_inflight = 0; m_lock = 0; m_idle = 0; m_rr = 0;
    e_ack = '0; e_req = 0; e_data = '0; e_gid = 0;
    sent.delete();
    stepn = 0; force_sack = 0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0; tail[i] = 0; present[i] = 0; rate[i] = 100; ack_step[i] = -1;
    end
  endtask

  task automatic take(input int c);
    e_gid      = c;
    e_data     = cl_data[8*c +: 8];
    m_lock     = !cl_last[c];
    e_ack[c]   = 1'b1;
    e_req      = 1'b1;
    m_inflight = 1;
    ack_step[c] = stepn;
    if (!rnd_mode) wait_cnt = 1;
    else wait_cnt = ($urandom_range(0, 4) == 0) ? $urandom_range(5, 12) : $urandom_range(0, 2);
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step();
    bit found;
    stepn++;
    if (m_inflight) begin
      if (wait_cnt == 0) ser_ack = 1'b1;
      else begin ser_ack = 1'b0; wait_cnt--; end
    end else begin
      ser_ack = force_sack || (spur_en && $urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < N; i++) begin
      if (!present[i] && head[i] < tail[i] && $urandom_range(1, 100) <= rate[i]) present[i] = 1;
      cl_req[i]        = present[i];
      cl_data[8*i +: 8] = (head[i] < tail[i]) ? cq[i][head[i]][7:0] : 8'h00;
      cl_last[i]       = (head[i] < tail[i]) ? cq[i][head[i]][8] : 1'b0;
    end

    e_ack = '0;
    if (m_inflight) begin
      if (ser_ack) begin
        sent.push_back(e_data);
        m_inflight = 0;
        e_req = 0;
        if (m_lock) m_idle = 0;
        else m_rr = (e_gid + 1) % N;
      end
    end else if (m_lock) begin
      if (cl_req[e_gid]) take(e_gid);
      else if (m_idle == TO - 1) begin
        m_lock = 0;
        m_rr = (e_gid + 1) % N;
      end else m_idle++;
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && cl_req[(m_rr + k) % N]) begin
          found = 1;
          take((m_rr + k) % N);
        end
      end
    end

    @(posedge clk);
    #1;
    check("cl_ack", {28'd0, cl_ack}, {28'd0, e_ack});
    check("ser_req", {31'd0, ser_req}, {31'd0, e_req});
    check("ser_data", {24'd0, ser_data}, {24'd0, e_data});
    check("grant_id", {30'd0, grant_id}, e_gid);
    check("busy", {31'd0, busy}, {31'd0, (m_inflight || m_lock)});
    for (int i = 0; i < N; i++) begin
      if (e_ack[i]) begin
        head[i]++;
        present[i] = 0;
      end
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    cl_req = '0; cl_data = '0; cl_last = '0; ser_ack = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_cl_ack", {28'd0, cl_ack}, 32'd0);
    check("rst_ser_req", {31'd0, ser_req}, 32'd0);
    check("rst_ser_data", {24'd0, ser_data}, 32'd0);
    check("rst_grant_id", {30'd0, grant_id}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int max_cycles);
    bit done;
    done = 0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      step();
      done = !m_inflight && !m_lock;
      for (int i = 0; i < N; i++) if (head[i] < tail[i]) done = 0;
    end
    check("drain", {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    rnd_mode = 0; spur_en = 0;

    // Single client 2, byte 0x41, idle serializer.
    reset_dut();
    push(2, 1, 8'h41);
    step();
    check("t1_ack", {28'd0, cl_ack}, 32'b0100);
    check("t1_data", {24'd0, ser_data}, 32'h41);
    check("t1_req", {31'd0, ser_req}, 32'd1);
    step();
    check("t1_req_hold", {31'd0, ser_req}, 32'd1);
    check("t1_ack_pulse", {28'd0, cl_ack}, 32'd0);
    step();
    check("t1_req_drop", {31'd0, ser_req}, 32'd0);
    check("t1_model_rr", m_rr, 32'd3);
    push(0, 1, 8'h01);
    push(3, 1, 8'h03);
    step();
    check("t1_rr_next", {30'd0, grant_id}, 32'd3);
    drain(100);

    // All four clients streaming single-byte messages.
    reset_dut();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) push(i, 1, 8'h10 + 8'(i));
    drain(300);
    check("rot0", sent_at(0), 32'h10);
    check("rot1", sent_at(1), 32'h11);
    check("rot2", sent_at(2), 32'h12);
    check("rot3", sent_at(3), 32'h13);
    check("rot4", sent_at(4), 32'h10);

    // Locked message from client 1 with client 0 waiting.
    reset_dut();
    push(1, 0, 8'hAA);
    push(1, 0, 8'hBB);
    push(1, 1, 8'hCC);
    step();
    push(0, 1, 8'h5A);
    drain(200);
    check("lock0", sent_at(0), 32'hAA);
    check("lock1", sent_at(1), 32'hBB);
    check("lock2", sent_at(2), 32'hCC);
    check("lock3", sent_at(3), 32'h5A);

    // Client 3 stalls inside a message; the lock times out.
    reset_dut();
    push(3, 0, 8'h77);
    step();
    push(0, 1, 8'h55);
    drain(200);
    check("to0", sent_at(0), 32'h77);
    check("to1", sent_at(1), 32'h55);
    check("to_ack_cycle", ack_step[0], 32'd12);

    // Reset asserted while a byte is in S_ISSUE.
    reset_dut();
    push(1, 1, 8'h31);
    drain(100);
    push(2, 1, 8'h32);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ser_req", {31'd0, ser_req}, 32'd0);
    check("arst_cl_ack", {28'd0, cl_ack}, 32'd0);
    check("arst_ser_data", {24'd0, ser_data}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    reset_dut();
    push(1, 1, 8'h41);
    push(3, 1, 8'h43);
    step();
    check("arst_rr_zero", {30'd0, grant_id}, 32'd1);
    drain(100);

    // Spurious ser_ack while idle.
    force_sack = 1;
    step();
    force_sack = 0;
    check("spur_ack", {28'd0, cl_ack}, 32'd0);
    check("spur_busy", {31'd0, busy}, 32'd0);
    check("spur_req", {31'd0, ser_req}, 32'd0);

    // Randomized traffic: multi-byte messages, slow clients, busy serializer.
    reset_dut();
    rnd_mode = 1;
    spur_en = 1;
    for (int i = 0; i < N; i++) begin
      rate[i] = $urandom_range(15, 100);
      while (tail[i] < 40) begin
        int len;
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) push(i, (k == len - 1), 8'($urandom));
      end
    end
    drain(20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
